pipe_mem_arbiter: RTL

Arbitrates one single-port unified memory between the IF stage (instruction read) and the MEM stage (data read/write) of the five-stage pipeline. Each access runs as a registered request/complete transaction with variable memory latency. The block drives per-requester stall outputs, which the hazard unit folds into StallF/StallD/FlushE. A watchdog flags a memory that never responds.

---
 rtl/pipe_mem_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_mem_arbiter.sv
// rtl/pipe_mem_arbiter.sv - single-port memory arbiter between IF fetch and MEM data access
// Optional round-robin arbitration when ARB_RR_EN is defined (default: data-over-fetch priority).
module pipe_mem_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int TMO_CYC = 15
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_done,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_wtype,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_done,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              tmo_err
);

    typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

    localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(3));
    localparam logic [7:0]        TMO_LIM   = 8'(TMO_CYC);

    state_t            state, state_nxt;
    logic [7:0]        wdog, wdog_nxt, wdog_inc;
    logic              mem_req_nxt, mem_we_nxt;
    logic [3:0]        mem_be_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [31:0]       mem_wdata_nxt;
    logic              if_done_nxt, d_done_nxt, tmo_err_nxt;
    logic [31:0]       if_rdata_nxt, d_rdata_nxt;
    logic              if_elig, d_elig, grant_d, grant_i;
    logic [3:0]        data_be;
    logic [31:0]       data_wdata;

    assign if_stall = if_req & ~if_done;
    assign d_stall  = d_req & ~d_done;

    // A requester whose done is high this cycle is not eligible, so it is never re-granted.
    assign if_elig = if_req & ~if_done;
    assign d_elig  = d_req & ~d_done;

`ifdef ARB_RR_EN
    logic last_grant;

    assign grant_d = d_elig & (~if_elig | ~last_grant);

    always_ff @(posedge clk) begin
        if (clr) begin
            last_grant <= 1'b0;
        end else if (state == IDLE && (grant_d || grant_i)) begin
            last_grant <= grant_d;
        end
    end
`else
    assign grant_d = d_elig;
`endif
    assign grant_i = if_elig & ~grant_d;

    always_comb begin
        data_be    = 4'b1111;
        data_wdata = d_wdata;
        if (d_we) begin
            case (d_wtype)
                3'b001: begin
                    data_be    = d_addr[1] ? 4'b1100 : 4'b0011;
                    data_wdata = {2{d_wdata[15:0]}};
                end
                3'b010: begin
                    data_be    = 4'b0001 << d_addr[1:0];
                    data_wdata = {4{d_wdata[7:0]}};
                end
                default: begin
                    data_be    = 4'b1111;
                    data_wdata = d_wdata;
                end
            endcase
        end
    end

    always_comb begin
        state_nxt     = state;
        wdog_nxt      = wdog;
        wdog_inc      = wdog + 8'd1;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_be_nxt    = mem_be;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        if_done_nxt   = 1'b0;
        d_done_nxt    = 1'b0;
        tmo_err_nxt   = tmo_err;
        if_rdata_nxt  = if_rdata;
        d_rdata_nxt   = d_rdata;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt     = DBUSY;
                    wdog_nxt      = 8'd0;
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = d_we;
                    mem_be_nxt    = data_be;
                    mem_addr_nxt  = d_addr & WORD_MASK;
                    mem_wdata_nxt = data_wdata;
                end else if (grant_i) begin
                    state_nxt     = IBUSY;
                    wdog_nxt      = 8'd0;
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = 1'b0;
                    mem_be_nxt    = 4'b1111;
                    mem_addr_nxt  = if_addr & WORD_MASK;
                    mem_wdata_nxt = 32'h0;
                end
            end
            IBUSY, DBUSY: begin
                if (mem_ready) begin
                    state_nxt   = IDLE;
                    mem_req_nxt = 1'b0;
                    if (state == IBUSY) begin
                        if_done_nxt  = 1'b1;
                        if_rdata_nxt = mem_rdata;
                    end else begin
                        d_done_nxt = 1'b1;
                        if (!mem_we) d_rdata_nxt = mem_rdata;
                    end
                // Timeout fires at the end of busy cycle TMO_CYC; a late ready in that cycle still wins.
                end else if (wdog_inc == TMO_LIM) begin
                    state_nxt   = IDLE;
                    mem_req_nxt = 1'b0;
                    tmo_err_nxt = 1'b1;
                    if (state == IBUSY) begin
                        if_done_nxt  = 1'b1;
                        if_rdata_nxt = 32'h0;
                    end else begin
                        d_done_nxt  = 1'b1;
                        d_rdata_nxt = 32'h0;
                    end
                end else begin
                    wdog_nxt = wdog_inc;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= IDLE;
            wdog      <= 8'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
            tmo_err   <= 1'b0;
            if_rdata  <= 32'h0;
            d_rdata   <= 32'h0;
        end else begin
            state     <= state_nxt;
            wdog      <= wdog_nxt;
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_be    <= mem_be_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            if_done   <= if_done_nxt;
            d_done    <= d_done_nxt;
            tmo_err   <= tmo_err_nxt;
            if_rdata  <= if_rdata_nxt;
            d_rdata   <= d_rdata_nxt;
        end
    end

endmodule
